// File: rtl/lut_neuron_scheduler.sv
// Time-multiplexes one shared LUT bank across a layer of LUT neurons.
// A frame of pre-gathered addresses is latched, one read is issued per cycle,
// results are captured through a latency-matched tag pipeline, and the full
// result vector is presented with a valid/ready handshake.
module lut_neuron_scheduler #(
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned IN_W        = 6,
    parameter int unsigned OUT_W       = 2,
    parameter int unsigned LUT_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [IN_W*NUM_NEURONS-1:0]  s_addr,
    output logic                         lut_en,
    output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] lut_idx,
    output logic [IN_W-1:0]              lut_addr,
    input  logic [OUT_W-1:0]             lut_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [OUT_W*NUM_NEURONS-1:0] m_data,
    output logic                         busy
);

    localparam int unsigned IDX_W    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int unsigned DRN_W    = 2;
    localparam int unsigned LAST_IDX = NUM_NEURONS - 1;
    localparam int unsigned LAST_DRN = LUT_LAT - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                       state, state_n;
    logic [IDX_W-1:0]             cnt, cnt_n;
    logic [DRN_W-1:0]             dcnt, dcnt_n;
    logic [IN_W*NUM_NEURONS-1:0]  frame, frame_n;

    logic                         s_ready_n;
    logic                         busy_n;
    logic                         m_valid_n;
    logic                         lut_en_n;
    logic [IDX_W-1:0]             lut_idx_n;
    logic [IN_W-1:0]              lut_addr_n;

    logic                         tag_v   [LUT_LAT];
    logic [IDX_W-1:0]             tag_idx [LUT_LAT];

    // Next-state, counters and next-cycle output values.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dcnt_n  = dcnt;
        frame_n = frame;

        case (state)
            IDLE: begin
                if (s_valid) begin
                    frame_n = s_addr;
                    cnt_n   = '0;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == IDX_W'(LAST_IDX)) begin
                    dcnt_n  = '0;
                    state_n = DRAIN;
                end else begin
                    cnt_n = cnt + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (dcnt == DRN_W'(LAST_DRN)) begin
                    state_n = OUT;
                end else begin
                    dcnt_n = dcnt + DRN_W'(1);
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        s_ready_n  = (state_n == IDLE);
        busy_n     = (state_n != IDLE);
        m_valid_n  = (state_n == OUT);
        lut_en_n   = (state_n == ISSUE);
        lut_idx_n  = lut_en_n ? cnt_n : '0;
        lut_addr_n = lut_en_n ? frame_n[32'(cnt_n) * IN_W +: IN_W] : '0;
    end

    // State, counters, frame register and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dcnt     <= '0;
            frame    <= '0;
            s_ready  <= 1'b1;
            busy     <= 1'b0;
            m_valid  <= 1'b0;
            lut_en   <= 1'b0;
            lut_idx  <= '0;
            lut_addr <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dcnt     <= dcnt_n;
            frame    <= frame_n;
            s_ready  <= s_ready_n;
            busy     <= busy_n;
            m_valid  <= m_valid_n;
            lut_en   <= lut_en_n;
            lut_idx  <= lut_idx_n;
            lut_addr <= lut_addr_n;
        end
    end

    // Tag pipeline tracks which neuron each returning LUT word belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LUT_LAT; i++) begin
                tag_v[i]   <= 1'b0;
                tag_idx[i] <= '0;
            end
        end else begin
            tag_v[0]   <= lut_en;
            tag_idx[0] <= lut_idx;
            for (int unsigned i = 1; i < LUT_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    // Capture tagged LUT results into their neuron slot; untagged data is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data <= '0;
        end else if (tag_v[LUT_LAT-1]) begin
            m_data[32'(tag_idx[LUT_LAT-1]) * OUT_W +: OUT_W] <= lut_data;
        end
    end

endmodule

// File: tb/tb_lut_neuron_scheduler.sv
// Bench for lut_neuron_scheduler: default configuration checked every cycle
// against a frame-level timing/result model, plus a NUM_NEURONS=1, LUT_LAT=3
// instance exercised with directed literal expectations.
module tb_lut_neuron_scheduler;

    localparam int N  = 16;
    localparam int L  = 1;
    localparam int IW = 6;
    localparam int OW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Default instance signals
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [IW*N-1:0]   s_addr = '0;
    logic              lut_en;
    logic [3:0]        lut_idx;
    logic [IW-1:0]     lut_addr;
    logic [OW-1:0]     lut_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [OW*N-1:0]   m_data;
    logic              busy;

    // NUM_NEURONS=1, LUT_LAT=3 instance signals
    logic              s1_valid = 1'b0;
    logic              s1_ready;
    logic [IW-1:0]     s1_addr = '0;
    logic              lut1_en;
    logic [0:0]        lut1_idx;
    logic [IW-1:0]     lut1_addr;
    logic [OW-1:0]     lut1_data;
    logic              m1_valid;
    logic              m1_ready = 1'b0;
    logic [OW-1:0]     m1_data;
    logic              busy1;

    lut_neuron_scheduler #(.NUM_NEURONS(N), .IN_W(IW), .OUT_W(OW), .LUT_LAT(L)) u0 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .lut_en(lut_en), .lut_idx(lut_idx), .lut_addr(lut_addr), .lut_data(lut_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
    );

    lut_neuron_scheduler #(.NUM_NEURONS(1), .IN_W(IW), .OUT_W(OW), .LUT_LAT(3)) u1 (
        .clk(clk), .rst(rst),
        .s_valid(s1_valid), .s_ready(s1_ready), .s_addr(s1_addr),
        .lut_en(lut1_en), .lut_idx(lut1_idx), .lut_addr(lut1_addr), .lut_data(lut1_data),
        .m_valid(m1_valid), .m_ready(m1_ready), .m_data(m1_data), .busy(busy1)
    );

    always #5 clk = ~clk;

    // LUT bank models: addr[1:0]^idx[1:0] after the read latency, noise otherwise.
    logic [OW-1:0] pipe0;
    logic [OW-1:0] pipe1 [3];
    logic [1:0]    idx1_pad;
    assign idx1_pad  = {1'b0, lut1_idx};
    assign lut_data  = pipe0;
    assign lut1_data = pipe1[2];

    always @(posedge clk) begin
        pipe0    <= lut_en ? (lut_addr[1:0] ^ lut_idx[1:0]) : 2'($urandom);
        pipe1[0] <= lut1_en ? (lut1_addr[1:0] ^ idx1_pad) : 2'($urandom);
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Frame-level model state
    bit            act = 1'b0;
    int            k   = 0;
    logic [IW-1:0] fr  [N];
    logic [OW*N-1:0] emd = '0;
    int            acc_cyc = 0;
    int            mv_cyc  = 0;
    bit            mv_seen = 1'b0;
    int            len_cnt = 0;
    logic [OW*N-1:0] got_md = '0;
    int            acc_hist [$];

    task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act_v, exp_v, cyc);
        end
    endtask

    // Expected outputs for the current cycle, derived from cycles since accept.
    task automatic model_check();
        bit            e_en;
        bit            e_mv;
        logic [3:0]    e_idx;
        logic [IW-1:0] e_addr;
        e_en   = act && (k >= 1) && (k <= N);
        e_mv   = act && (k >= N + L + 1);
        e_idx  = '0;
        e_addr = '0;
        if (e_en) begin
            e_idx  = 4'(k - 1);
            e_addr = fr[k-1];
        end
        chk("s_ready", 64'(s_ready), 64'(!act));
        chk("busy", 64'(busy), 64'(act));
        chk("lut_en", 64'(lut_en), 64'(e_en));
        chk("lut_idx", 64'(lut_idx), 64'(e_idx));
        chk("lut_addr", 64'(lut_addr), 64'(e_addr));
        chk("m_valid", 64'(m_valid), 64'(e_mv));
        if (e_mv) chk("m_data", 64'(m_data), 64'(emd));
        if (m_valid && !mv_seen) begin
            mv_seen = 1'b1;
            mv_cyc  = cyc;
            got_md  = m_data;
        end
        if (lut_en) len_cnt++;
    endtask

    // Advance the model using the inputs seen at the coming clock edge.
    task automatic model_update();
        if (rst) begin
            act = 1'b0;
        end else if (!act) begin
            if (s_valid) begin
                act = 1'b1;
                k   = 1;
                for (int i = 0; i < N; i++) begin
                    fr[i] = s_addr[i*IW +: IW];
                    emd[i*OW +: OW] = s_addr[i*IW +: 2] ^ 2'(i);
                end
                acc_cyc = cyc;
                acc_hist.push_back(cyc);
                mv_seen = 1'b0;
                len_cnt = 0;
            end
        end else if (k >= N + L + 1) begin
            if (m_ready) act = 1'b0;
        end else begin
            k++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk_en) model_check();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_frame(input logic [IW*N-1:0] a, input int hold);
        int n;
        bit acc;
        s_addr  = a;
        s_valid = 1'b1;
        m_ready = 1'b0;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            acc = !act && !rst;
            cycle();
            n++;
        end
        chk("accept_timeout", 64'(acc), 64'(1));
        s_valid = 1'b0;
        n = 0;
        while (!m_valid && n < 100) begin
            cycle();
            n++;
        end
        chk("m_valid_timeout", 64'(m_valid), 64'(1));
        repeat (hold) cycle();
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        chk("idle_after_handshake", 64'(s_ready), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW*N-1:0] a;
        logic [IW-1:0]   a1;
        int t0;
        int n;

        // Reset and reset-state literals
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        chk("rst_s_ready", 64'(s_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_lut_en", 64'(lut_en), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        chk("rst_u1_s_ready", 64'(s1_ready), 64'(1));
        chk_en = 1'b1;

        // Addresses equal to neuron index: all results zero, fixed latency
        for (int i = 0; i < N; i++) a[i*IW +: IW] = IW'(i);
        send_frame(a, 0);
        chk("lat_first_frame", 64'(mv_cyc - acc_cyc), 64'(18));
        chk("issue_count", 64'(len_cnt), 64'(16));
        chk("md_index_frame", 64'(got_md), 64'(0));

        // Every address 6'b000011: slots 3,2,1,0 repeating
        a = {N{6'b000011}};
        send_frame(a, 0);
        chk("md_const_frame", 64'(got_md), 64'(32'h1B1B1B1B));

        // Back-pressure: m_ready low for 5 cycles after m_valid
        a = {$urandom, $urandom, $urandom};
        send_frame(a, 5);
        chk("md_backpressure", 64'(got_md), 64'(emd));

        // Continuous s_valid with changing frames
        acc_hist.delete();
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            s_addr = {$urandom, $urandom, $urandom};
            cycle();
        end
        s_valid = 1'b0;
        n = 0;
        while (act && n < 100) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 64'(act), 64'(0));
        m_ready = 1'b0;
        chk("accept_count", 64'(acc_hist.size() >= 5), 64'(1));
        for (int i = 1; i < acc_hist.size(); i++)
            chk("accept_period", 64'(acc_hist[i] - acc_hist[i-1]), 64'(19));

        // Reset in the middle of ISSUE
        cycle();
        s_addr  = {$urandom, $urandom, $urandom};
        s_valid = 1'b1;
        t0 = cyc;
        cycle();
        s_valid = 1'b0;
        chk("rst_frame_accepted", 64'(acc_cyc), 64'(t0));
        while (cyc < t0 + 8) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (30) cycle();
        m_ready = 1'b0;
        chk("no_m_valid_after_rst", 64'(mv_seen), 64'(0));
        chk("idle_after_rst", 64'(s_ready), 64'(1));
        a = {$urandom, $urandom, $urandom};
        send_frame(a, 2);
        chk("md_after_rst", 64'(got_md), 64'(emd));

        // Random traffic with occasional reset
        for (int c = 0; c < 1500; c++) begin
            s_valid = ($urandom_range(0, 2) == 0);
            m_ready = $urandom_range(0, 1) == 1;
            s_addr  = {$urandom, $urandom, $urandom};
            rst     = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (30) cycle();
        m_ready = 1'b0;

        // Single neuron, three-cycle LUT latency
        for (int r = 0; r < 4; r++) begin
            a1 = IW'($urandom);
            s1_addr  = a1;
            s1_valid = 1'b1;
            m1_ready = 1'b1;
            cycle();
            chk("u1_issue_en", 64'(lut1_en), 64'(1));
            chk("u1_issue_addr", 64'(lut1_addr), 64'(a1));
            chk("u1_issue_idx", 64'(lut1_idx), 64'(0));
            chk("u1_busy", 64'(busy1), 64'(1));
            chk("u1_s_ready_busy", 64'(s1_ready), 64'(0));
            s1_addr = ~a1;
            for (int j = 2; j <= 4; j++) begin
                cycle();
                chk("u1_drain_en", 64'(lut1_en), 64'(0));
                chk("u1_drain_addr", 64'(lut1_addr), 64'(0));
                chk("u1_drain_m_valid", 64'(m1_valid), 64'(0));
            end
            s1_valid = 1'b0;
            cycle();
            chk("u1_m_valid", 64'(m1_valid), 64'(1));
            chk("u1_m_data", 64'(m1_data), 64'(a1[1:0]));
            cycle();
            chk("u1_m_valid_clear", 64'(m1_valid), 64'(0));
            chk("u1_s_ready_back", 64'(s1_ready), 64'(1));
        end
        m1_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
